// File: rtl/calc2_resp_engine.sv
// calc2_resp_engine: responder end of one calc2 port; tagged two-cycle commands, four slots.
// Optional macro CALC2_INORDER_EN: responses leave in issue order through a tag FIFO.
module calc2_resp_engine #(
  parameter int ADD_LAT = 3,
  parameter int SHIFT_LAT = 5
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req_cmd_in,
  input  logic [31:0] req_data_in,
  input  logic [1:0]  req_tag_in,
  output logic [1:0]  out_resp,
  output logic [31:0] out_data,
  output logic [1:0]  out_tag,
  output logic        dup_tag_err
);
  localparam logic [3:0] ADD_L = 4'(ADD_LAT);
  localparam logic [3:0] SHIFT_L = 4'(SHIFT_LAT);
  typedef enum logic {IDLE, OP2} state_t;
  state_t r_state, w_next;
  logic [3:0]  r_cmd;
  logic [31:0] r_op1;
  logic [1:0]  r_tag;
  logic [3:0]  r_vld;
  logic [31:0] r_res [4];
  logic [1:0]  r_code [4];
  logic [3:0]  r_cnt [4];
  logic        w_issue, w_dup, w_sel_v;
  logic [32:0] w_sum;
  logic [31:0] w_res;
  logic [1:0]  w_code, w_sel;
  logic [3:0]  w_lat, w_rdy;

  always_comb w_next = (r_state == IDLE && req_cmd_in != 4'h0) ? OP2 : IDLE;
  assign w_issue = r_state == OP2;
  assign w_dup = w_issue && r_vld[r_tag];
  assign w_sum = {1'b0, r_op1} + {1'b0, req_data_in};

  always_comb begin
    w_res = '0;
    w_code = 2'b10;
    w_lat = ADD_L;
    case (r_cmd)
      4'h1: begin
        w_code = w_sum[32] ? 2'b10 : 2'b01;
        w_res = w_sum[32] ? '0 : w_sum[31:0];
      end
      4'h2: begin
        w_code = (r_op1 < req_data_in) ? 2'b10 : 2'b01;
        w_res = (r_op1 < req_data_in) ? '0 : r_op1 - req_data_in;
      end
      4'h5: begin
        w_code = 2'b01;
        w_res = r_op1 << req_data_in[4:0];
        w_lat = SHIFT_L;
      end
      4'h6: begin
        w_code = 2'b01;
        w_res = r_op1 >> req_data_in[4:0];
        w_lat = SHIFT_L;
      end
      default: ;
    endcase
  end

  // a slot at 1 reaches 0 on this edge, so it can be picked now to meet E1+LAT
  for (genvar i = 0; i < 4; i++) begin : g_rdy
    assign w_rdy[i] = r_vld[i] && r_cnt[i] <= 4'd1;
  end

`ifdef CALC2_INORDER_EN
  logic [1:0] r_fifo [4];
  logic [1:0] r_wr, r_rd;
  assign w_sel = r_fifo[r_rd];
  assign w_sel_v = w_rdy[w_sel];
  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_issue && !w_dup) begin
        r_fifo[r_wr] <= r_tag;
        r_wr <= r_wr + 2'd1;
      end
      if (w_sel_v) r_rd <= r_rd + 2'd1;
    end
  end
`else
  assign w_sel = w_rdy[0] ? 2'd0 : w_rdy[1] ? 2'd1 : w_rdy[2] ? 2'd2 : 2'd3;
  assign w_sel_v = |w_rdy;
`endif

  always_ff @(posedge c_clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_vld <= '0;
      out_resp <= '0;
      out_data <= '0;
      out_tag <= '0;
      dup_tag_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && req_cmd_in != 4'h0) begin
        r_cmd <= req_cmd_in;
        r_op1 <= req_data_in;
        r_tag <= req_tag_in;
      end
      for (int i = 0; i < 4; i++) if (r_cnt[i] != 4'd0) r_cnt[i] <= r_cnt[i] - 4'd1;
      if (w_sel_v) r_vld[w_sel] <= 1'b0;
      if (w_issue && !w_dup) begin
        r_vld[r_tag] <= 1'b1;
        r_res[r_tag] <= w_res;
        r_code[r_tag] <= w_code;
        r_cnt[r_tag] <= w_lat;
      end
      out_resp <= w_sel_v ? r_code[w_sel] : 2'b00;
      out_data <= w_sel_v ? r_res[w_sel] : '0;
      out_tag <= w_sel_v ? w_sel : 2'd0;
      dup_tag_err <= w_dup;
    end
  end
endmodule

// File: tb/tb_calc2_resp_engine.sv
// tb_calc2_resp_engine: directed stimulus with a scoreboard queue and a decoupled monitor.
module tb_calc2_resp_engine;
  localparam int AL = 3;
  localparam int SL = 7;
  logic c_clk = 0;
  logic reset = 1;
  logic [3:0] req_cmd_in = 0;
  logic [31:0] req_data_in = 0;
  logic [1:0] req_tag_in = 0;
  logic [1:0] out_resp;
  logic [31:0] out_data;
  logic [1:0] out_tag;
  logic dup_tag_err;
  typedef struct {logic [1:0] resp; logic [31:0] data; logic [1:0] tag; int cyc;} exp_t;
  exp_t exp_q[$];
  int dup_q[$];
  exp_t e;
  int d, cyc = 0, checks = 0, errors = 0;
  int t0, t1, t2;

  calc2_resp_engine #(.ADD_LAT(AL), .SHIFT_LAT(SL)) dut (
    .c_clk(c_clk), .reset(reset), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
    .req_tag_in(req_tag_in), .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
    .dup_tag_err(dup_tag_err));

  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) cyc <= cyc + 1;

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge c_clk);
      #1;
    end
  endtask

  task automatic send(input logic [3:0] cmd, input logic [1:0] tag, input logic [31:0] a,
                      input logic [31:0] b, output int e1);
    req_cmd_in = cmd;
    req_tag_in = tag;
    req_data_in = a;
    idle(1);
    req_cmd_in = 0;
    req_tag_in = 0;
    req_data_in = b;
    idle(1);
    e1 = cyc;
    req_data_in = 0;
  endtask

  task automatic push(input logic [1:0] r, input logic [31:0] v, input logic [1:0] t, input int c);
    exp_q.push_back('{r, v, t, c});
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) idle(1);
    idle(2);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses still pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_zero(input string nm);
    checks++;
    if (out_resp != 0 || out_data != 0 || out_tag != 0 || dup_tag_err != 0) begin
      errors++;
      $display("FAIL %s: resp=%0h data=%h tag=%0d dup=%0b, required all 0", nm, out_resp, out_data,
               out_tag, dup_tag_err);
    end
  endtask

  initial begin
    fork
      forever begin
        @(negedge c_clk);
        if (!reset) begin
          if (out_resp != 2'b00) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL resp_unexpected: resp=%0h data=%h tag=%0d cyc=%0d, required none",
                       out_resp, out_data, out_tag, cyc);
            end else begin
              e = exp_q.pop_front();
              if (out_resp !== e.resp || out_data !== e.data || out_tag !== e.tag || cyc != e.cyc) begin
                errors++;
                $display("FAIL resp_tag%0d: got resp=%0h data=%h tag=%0d cyc=%0d, required resp=%0h data=%h tag=%0d cyc=%0d",
                         e.tag, out_resp, out_data, out_tag, cyc, e.resp, e.data, e.tag, e.cyc);
              end
            end
          end else if (out_data != 0 || out_tag != 0) begin
            checks++;
            errors++;
            $display("FAIL idle_outputs: data=%h tag=%0d with no response, required 0", out_data, out_tag);
          end
          if (dup_tag_err) begin
            checks++;
            if (dup_q.size() == 0) begin
              errors++;
              $display("FAIL dup_unexpected: pulse at cyc=%0d, required none", cyc);
            end else begin
              d = dup_q.pop_front();
              if (d != cyc) begin
                errors++;
                $display("FAIL dup_cycle: pulse at cyc=%0d, required cyc=%0d", cyc, d);
              end
            end
          end
        end
      end
    join_none
    idle(3);
    chk_zero("reset_state");
    reset = 0;
    send(4'h1, 2'd1, 32'h30, 32'h20, t0);
    push(2'b01, 32'h50, 2'd1, t0 + AL);
    drain();
    send(4'h1, 2'd0, 32'hFFFF_FFFF, 32'h1, t0);
    push(2'b10, 32'h0, 2'd0, t0 + AL);
    drain();
    send(4'h2, 2'd2, 32'd5, 32'd6, t0);
    push(2'b10, 32'h0, 2'd2, t0 + AL);
    send(4'h2, 2'd3, 32'd6, 32'd5, t1);
    push(2'b01, 32'd1, 2'd3, t1 + AL);
    drain();
    send(4'h6, 2'd2, 32'h8000_0000, 32'h3F, t0);
    push(2'b01, 32'h1, 2'd2, t0 + SL);
    drain();
    send(4'h5, 2'd0, 32'h1, 32'h4, t0);
    send(4'h1, 2'd1, 32'd2, 32'd3, t1);
`ifdef CALC2_INORDER_EN
    push(2'b01, 32'h10, 2'd0, t0 + SL);
    push(2'b01, 32'd5, 2'd1, t0 + SL + 1);
`else
    push(2'b01, 32'd5, 2'd1, t1 + AL);
    push(2'b01, 32'h10, 2'd0, t0 + SL);
`endif
    drain();
    send(4'h1, 2'd2, 32'd10, 32'd20, t0);
    push(2'b01, 32'd30, 2'd2, t0 + AL);
    send(4'h2, 2'd2, 32'd100, 32'd1, t1);
    dup_q.push_back(t1);
    send(4'h1, 2'd2, 32'd1, 32'd1, t2);
    push(2'b01, 32'd2, 2'd2, t2 + AL);
    drain();
    send(4'h1, 2'd3, 32'd4, 32'd5, t0);
    push(2'b01, 32'd9, 2'd3, t0 + AL);
    idle(1);
    send(4'h1, 2'd3, 32'd7, 32'd7, t1);
    dup_q.push_back(t1);
    drain();
    send(4'h3, 2'd3, 32'd9, 32'd9, t0);
    push(2'b10, 32'h0, 2'd3, t0 + AL);
    drain();
    req_cmd_in = 4'h1;
    req_data_in = 32'd7;
    idle(1);
    reset = 1;
    req_cmd_in = 0;
    req_data_in = 32'd8;
    idle(3);
    chk_zero("reset_in_op2");
    reset = 0;
    req_data_in = 0;
    idle(20);
    chk_zero("after_reset_op2");
    send(4'h5, 2'd0, 32'h1, 32'h1, t0);
    send(4'h5, 2'd1, 32'h1, 32'h2, t1);
    send(4'h5, 2'd2, 32'h1, 32'h3, t2);
    reset = 1;
    idle(2);
    chk_zero("reset_in_flight");
    reset = 0;
    idle(20);
    chk_zero("after_reset_flight");
    send(4'h1, 2'd1, 32'h100, 32'h23, t0);
    push(2'b01, 32'h123, 2'd1, t0 + AL);
    drain();
    checks++;
    if (dup_q.size() != 0) begin
      errors++;
      $display("FAIL dup_missing: %0d pulses not seen, required 0", dup_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
